// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: state and owner encodings shared by the memory port arbiter files.
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;
  typedef enum logic {
    OWNER_CPU  = 1'b0,
    OWNER_HOST = 1'b1
  } owner_e;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: host-priority winner selection with a saturating host-streak limit.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_HOST_STREAK = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   grant_i,
  input  logic   cpu_req_i,
  input  logic   host_req_i,
  output owner_e winner_o
);
  localparam int SW = $clog2(MAX_HOST_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_HOST_STREAK);
  logic [SW-1:0] streak_q, streak_d;
  logic          streak_full;
  assign streak_full = streak_q == STREAK_MAX;
  // The CPU only overrides the host once the host has used up its streak.
  always_comb winner_o = (cpu_req_i && (!host_req_i || streak_full)) ? OWNER_CPU : OWNER_HOST;
  always_comb begin
    streak_d = !grant_i ? streak_q :
               winner_o == OWNER_CPU ? '0 :
               streak_full ? streak_q : streak_q + 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) streak_q <= '0;
    else       streak_q <= streak_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises CPU and host transactions onto the single memory port.
// Define ARB_TIMEOUT_EN to abort a transaction that sees no mem_ack within TIMEOUT BUSY cycles.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_HOST_STREAK = 4,
  parameter int TIMEOUT         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ready,
  output logic              host_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              owner
);
  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d, winner;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic              grant, done, tmo_hit;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, host_rdata_q, host_rdata_d, rdata_in;

  assign grant    = state_q == ARB_IDLE && (cpu_req || host_req);
  assign done     = state_q == ARB_BUSY && (mem_ack || tmo_hit);
  assign rdata_in = (mem_ack && !mem_we_q) ? mem_rdata : '0;

  mem_arb_pick #(.MAX_HOST_STREAK(MAX_HOST_STREAK)) u_pick (
    .clk        (clk),
    .reset      (reset),
    .grant_i    (grant),
    .cpu_req_i  (cpu_req),
    .host_req_i (host_req),
    .winner_o   (winner)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  // An ack in the final cycle wins over the abort.
  assign tmo_hit = state_q == ARB_BUSY && !mem_ack && tmo_q == TMO_LAST;
  assign tmo_d   = state_q == ARB_BUSY ? tmo_q + 1'b1 : '0;
  assign err_d   = done ? !mem_ack : err_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign cpu_err  = cpu_ready && err_q;
  assign host_err = host_ready && err_q;
`else
  assign tmo_hit  = 1'b0;
  assign cpu_err  = 1'b0;
  assign host_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    case (state_q)
      ARB_IDLE: if (grant) begin
        state_d     = ARB_BUSY;
        owner_d     = winner;
        mem_req_d   = 1'b1;
        mem_we_d    = winner == OWNER_HOST ? host_we : cpu_we;
        mem_addr_d  = winner == OWNER_HOST ? host_addr : cpu_addr;
        mem_wdata_d = winner == OWNER_HOST ? host_wdata : cpu_wdata;
      end
      ARB_BUSY: if (done) begin
        state_d      = ARB_RESP;
        mem_req_d    = 1'b0;
        host_rdata_d = owner_q == OWNER_HOST ? rdata_in : host_rdata_q;
        cpu_rdata_d  = owner_q == OWNER_CPU ? rdata_in : cpu_rdata_q;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWNER_CPU;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign cpu_ready  = state_q == ARB_RESP && owner_q == OWNER_CPU;
  assign host_ready = state_q == ARB_RESP && owner_q == OWNER_HOST;
  assign cpu_rdata  = cpu_rdata_q;
  assign host_rdata = host_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = state_q != ARB_IDLE;
  assign owner      = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, corner sequences and a randomized transaction-level model check.
module tb_mem_port_arbiter;
  localparam int MAXS = 4;

  typedef struct {
    bit          host;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wt;
    logic [31:0] rd;
  } vec_t;

  logic        clk = 1'b0, reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, host_req = 1'b0, host_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, host_addr = '0, host_wdata = '0;
  logic [31:0] cpu_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ready, cpu_err, host_ready, host_err;
  logic        mem_req, mem_we, mem_ack, busy, owner;

  bit [31:0]   smem    [256];
  bit [31:0]   ref_mem [256];
  int          wait_cfg = 0, wcnt = 0;
  bit          no_ack = 1'b0;
  int          n_vec = 0, n_err = 0;
  logic [31:0] exp_crd = '0, exp_hrd = '0;

  bit          fl, rs, own, cur_we;
  logic [31:0] cur_addr, cur_wd, rd;
  int          streak;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .cpu_err    (cpu_err),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_ready (host_ready),
    .host_err   (host_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .owner      (owner)
  );

  // Memory slave: acks after wait_cfg stall cycles, zero-wait acks in the first request cycle.
  assign mem_ack   = mem_req && !no_ack && wcnt == wait_cfg;
  assign mem_rdata = smem[mem_addr[7:0]];
  always @(posedge clk) begin
    wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
    if (mem_req && mem_ack && mem_we) smem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_req = 1'b0;
    host_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_crd = '0;
    exp_hrd = '0;
  endtask

  task automatic run_vec(input vec_t v);
    int  lat;
    bit  seen;
    wait_cfg = v.wt;
    if (v.host) begin
      host_req = 1'b1; host_we = v.we; host_addr = v.addr; host_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (mem_req) begin
        chk("vec_mem_we", mem_we, v.we);
        chk("vec_mem_addr", mem_addr, v.addr);
        chk("vec_mem_wdata", mem_wdata, v.wdata);
        chk("vec_owner", owner, v.host);
      end
      chk("vec_other_ready", v.host ? cpu_ready : host_ready, 0);
      seen = v.host ? host_ready : cpu_ready;
    end
    chk("vec_latency", lat, v.wt + 2);
    chk("vec_rdata", v.host ? host_rdata : cpu_rdata, v.rd);
    chk("vec_other_rdata", v.host ? cpu_rdata : host_rdata, v.host ? exp_crd : exp_hrd);
    chk("vec_err", v.host ? host_err : cpu_err, 0);
    if (v.host) exp_hrd = v.rd; else exp_crd = v.rd;
    if (v.we) ref_mem[v.addr[7:0]] = v.wdata;
    cpu_req = 1'b0;
    host_req = 1'b0;
    @(negedge clk);
    chk("vec_single_pulse", cpu_ready | host_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  initial begin
    vec_t tbl [8];
    bit   exp_order [10];
    int   n, cyc;
    bit   seen;
    tbl[0] = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 32'h10, 32'h0,        0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b1, 32'h40, 32'h12345678, 3, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 32'h40, 32'h0,        1, 32'h12345678};
    tbl[4] = '{1'b1, 1'b0, 32'h10, 32'h0,        2, 32'hDEADBEEF};
    tbl[5] = '{1'b0, 1'b1, 32'h80, 32'hA5A50F0F, 0, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 32'h80, 32'h0,        0, 32'hA5A50F0F};
    tbl[7] = '{1'b0, 1'b0, 32'h10, 32'h0,        0, 32'hDEADBEEF};
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    @(negedge clk);
    @(negedge clk);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_host_ready", host_ready, 0);
    chk("rst_cpu_err", cpu_err, 0);
    chk("rst_host_err", host_err, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Both requesters held continuously: host gets MAX_HOST_STREAK grants, then the CPU one.
    do_reset();
    wait_cfg = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h40;
    n = 0;
    cyc = 0;
    while (n < 10 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (cpu_ready || host_ready) begin
        chk("pri_owner", owner, exp_order[n]);
        chk("pri_ready_port", host_ready, exp_order[n]);
        chk("pri_both_ready", cpu_ready & host_ready, 0);
        chk("pri_rdata", exp_order[n] ? host_rdata : cpu_rdata,
            exp_order[n] ? 32'h12345678 : 32'hDEADBEEF);
        n++;
      end
    end
    chk("pri_count", n, 10);
    cpu_req = 1'b0;
    host_req = 1'b0;
    @(negedge clk);

    // Reset in the middle of a stalled write discards it without a ready pulse.
    no_ack = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    chk("rstb_mem_req_before", mem_req, 1);
    #2 reset = 1'b1;
    #1;
    chk("rstb_mem_req_async", mem_req, 0);
    chk("rstb_busy_async", busy, 0);
    chk("rstb_ready_async", cpu_ready, 0);
    cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    no_ack = 1'b0;
    exp_crd = '0;
    exp_hrd = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstb_no_ready", cpu_ready | host_ready, 0);
      chk("rstb_idle", busy, 0);
    end
    run_vec('{1'b0, 1'b0, 32'h20, 32'h0, 0, 32'h0});
    run_vec('{1'b0, 1'b0, 32'h40, 32'h0, 1, 32'h12345678});

    // Memory that never acks.
    no_ack = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
`ifdef ARB_TIMEOUT_EN
    n = 0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (mem_req) n++;
      seen = cpu_ready;
    end
    chk("tmo_busy_cycles", n, 16);
    chk("tmo_ready", seen, 1);
    chk("tmo_cpu_err", cpu_err, 1);
    chk("tmo_cpu_rdata", cpu_rdata, 0);
    chk("tmo_host_ready", host_ready, 0);
    chk("tmo_host_err", host_err, 0);
    cpu_req = 1'b0;
    no_ack = 1'b0;
    @(negedge clk);
    chk("tmo_err_cleared", cpu_err, 0);
`else
    for (int i = 0; i < 40; i++) @(negedge clk);
    chk("notmo_mem_req_held", mem_req, 1);
    chk("notmo_no_ready", cpu_ready, 0);
    chk("notmo_no_err", cpu_err, 0);
    no_ack = 1'b0;
`endif

    // Randomized traffic against a transaction-level model.
    do_reset();
    fl = 1'b0;
    rs = 1'b0;
    own = 1'b0;
    streak = 0;
    cur_we = 1'b0;
    cur_addr = '0;
    cur_wd = '0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      chk("rnd_busy", busy, fl | rs);
      chk("rnd_mem_req", mem_req, fl);
      chk("rnd_cpu_ready", cpu_ready, rs & !own);
      chk("rnd_host_ready", host_ready, rs & own);
      chk("rnd_cpu_rdata", cpu_rdata, exp_crd);
      chk("rnd_host_rdata", host_rdata, exp_hrd);
      chk("rnd_err", cpu_err | host_err, 0);
      if (fl || rs) chk("rnd_owner", owner, own);
      if (fl) begin
        chk("rnd_mem_we", mem_we, cur_we);
        chk("rnd_mem_addr", mem_addr, cur_addr);
        chk("rnd_mem_wdata", mem_wdata, cur_wd);
      end
      if (rs) begin
        if (own) host_req = 1'b0; else cpu_req = 1'b0;
      end
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = $urandom; cpu_wdata = $urandom;
      end
      if (!host_req && $urandom_range(0, 2) == 0) begin
        host_req = 1'b1; host_we = 1'($urandom_range(0, 1));
        host_addr = $urandom; host_wdata = $urandom;
      end
      if (!mem_req) wait_cfg = $urandom_range(0, 3);
      if (rs) rs = 1'b0;
      else if (fl) begin
        if (mem_ack) begin
          fl = 1'b0;
          rs = 1'b1;
          rd = cur_we ? 32'h0 : ref_mem[cur_addr[7:0]];
          if (cur_we) ref_mem[cur_addr[7:0]] = cur_wd;
          if (own) exp_hrd = rd; else exp_crd = rd;
        end
      end else if (cpu_req || host_req) begin
        own = host_req && !(cpu_req && streak == MAXS);
        streak = own ? (streak < MAXS ? streak + 1 : MAXS) : 0;
        cur_we = own ? host_we : cpu_we;
        cur_addr = own ? host_addr : cpu_addr;
        cur_wd = own ? host_wdata : cpu_wdata;
        fl = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between two requesters: the multicycle CPU datapath (port C) and the host loader/debug port (port H).
- Serialises requests, forwards one transaction at a time to memory and returns read data with a one-cycle ready pulse.
- The CPU control sequencer holds its current state (INSTRUCTION_FETCH, LOAD4, STORE4, ...) while `cpu_ready` is low.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_HOST_STREAK, 4, number of consecutive host grants allowed while the CPU is waiting.
- TIMEOUT, 16, cycles to wait for `mem_ack` before aborting. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU transaction request; held until `cpu_ready`.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  read data; valid while `cpu_ready` is high.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  timeout flag, qualified by `cpu_ready`.
- host_req, host_we, host_addr, host_wdata, host_rdata, host_ready, host_err: same as the cpu_* ports, for the host.
- mem_req  out  1  request to memory; held until `mem_ack`.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid with `mem_ack`.
- mem_ack  in  1  memory completion; may arrive in the same cycle `mem_req` first rises.
- busy  out  1  high when state is not IDLE.
- owner  out  1  owner of the current transaction: 0 = CPU, 1 = host.

Behaviour:
- Reset: every output is 0, state is IDLE, the streak counter is 0.
  - Reset is asynchronous; `mem_req` drops immediately.
  - An in-flight transaction is discarded and no ready pulse is issued.
- State machine: IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - If any request is high, pick a winner and register the winner's we/addr/wdata onto the mem_* outputs.
  - Set `owner`, assert `mem_req` and go to BUSY.
  - If no request is high, stay in IDLE.
- Winner selection:
  - Host wins, unless `cpu_req` is high and streak == MAX_HOST_STREAK; then the CPU wins.
  - The streak increments, saturating, on each host grant and clears on each CPU grant.
- BUSY:
  - `mem_*` outputs are held stable.
  - On `mem_ack`: register `mem_rdata` (write → 0) into the owner's rdata register, deassert `mem_req` and go to RESP.
- RESP:
  - The owner's ready is 1 for exactly one cycle; the non-owner's ready stays 0.
  - Return to IDLE.
- Latency: the request sampled at edge N gives `mem_req` high at N+1. With a zero-wait ack, ready is high during cycle N+2. Throughput is one transaction per 3 cycles at best.
- Requester rules:
  - Hold req, we, addr and wdata stable until ready is sampled high.
  - Deassert req on that same edge.
  - Inputs from the non-owner are ignored until IDLE.
- Simultaneous requests in IDLE resolve by the priority rule. There is no grant while not in IDLE.
- rdata registers hold their value until the next completion for that port.
- A request arriving during BUSY/RESP is serviced on the next IDLE.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro: a counter clears on entry to BUSY and increments each BUSY cycle without `mem_ack`. When the count reaches TIMEOUT-1 with no ack:
  - deassert `mem_req`;
  - load rdata with 0;
  - set the owner's err to 1 together with its ready pulse in RESP.
  - An ack in that same cycle takes precedence (err = 0).
- Without the macro: BUSY waits indefinitely; `cpu_err` and `host_err` are tied to 0 and the ports remain present.

Decomposition:
- Shared header with:
  - state encoding: ARB_IDLE = 0, ARB_BUSY = 1, ARB_RESP = 2;
  - owner encoding: OWNER_CPU = 0, OWNER_HOST = 1.
- Sub-module mem_arb_pick: winner selection plus the saturating streak counter (clk, reset, grant strobe, requests → winner).

Test Plan:
- CPU-only read: addr 0x10, memory acks 0 wait, rdata 0xDEADBEEF. Required: `cpu_ready` 2 cycles after req sampled, `cpu_rdata` = 0xDEADBEEF, `host_ready` stays 0.
- Simultaneous `cpu_req` and `host_req` held continuously:
  - with MAX_HOST_STREAK = 4, grant order is H, H, H, H, C, H, ...;
  - `owner` matches each grant;
  - exactly one ready pulse per transaction.
- Host write: addr 0x40, wdata 0x12345678, ack after 3 wait cycles. Required: `mem_we` = 1 and addr/wdata stable through BUSY, `host_ready` one cycle after ack, then CPU read of 0x40 returns 0x12345678.
- Reset asserted during BUSY: `mem_req` drops asynchronously, `busy` = 0, no ready pulse, a fresh request afterwards completes normally.
- ARB_TIMEOUT_EN, TIMEOUT = 16, memory never acks: `mem_req` drops after 16 BUSY cycles, `cpu_ready` = 1 with `cpu_err` = 1 and `cpu_rdata` = 0. Without the macro, `mem_req` stays high indefinitely.
